// File: rtl/packet_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : packet_sequencer
// Description : Captures a 16-byte packet after a chip-select rising edge.
//               The edge comes from an external MCU and is resynchronised to
//               clk. The block waits a settle delay, checks the header byte,
//               then streams the packet one byte per valid/ready handshake.
//               It also keeps status flags and packet/drop counters.
// Ports       : clk, rst_n (sync, active-low)
//               cs_n        raw chip select, asynchronous to clk
//               pkt_data    16-byte packet, byte 0 in [127:120]
//               enable      gates new packet starts only
//               tx_data/tx_valid/tx_ready/tx_last  outgoing byte stream
//               busy, hdr_ok, hdr_err, overrun     status
//               pkt_count (wrapping), drop_count (saturating)
// Revision    : 1.0  initial release
// ============================================================================
module packet_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  HEADER_BYTE   = 8'hAA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cs_n,
  input  logic [127:0] pkt_data,
  input  logic         enable,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy,
  output logic         hdr_ok,
  output logic         hdr_err,
  output logic         overrun,
  output logic [15:0]  pkt_count,
  output logic [7:0]   drop_count
);

  localparam int unsigned c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_SEND   = 2'd3
  } state_t;

  state_t               state_q;
  logic                 cs_sync1_q;
  logic                 cs_sync2_q;
  logic                 cs_prev_q;
  logic [c_cnt_w-1:0]   settle_cnt_q;
  logic [3:0]           idx_q;
  logic [7:0]           snap_q [16];
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic                 tx_last_q;
  logic                 hdr_ok_q;
  logic                 hdr_err_q;
  logic                 overrun_q;
  logic [15:0]          pkt_count_q;
  logic [7:0]           drop_count_q;
  logic [7:0]           drop_count_d;

  logic                 w_cs_rise;
  logic                 w_hdr_good;
  logic [3:0]           w_next_idx;
  logic [1:0]           w_drop_inc;
  logic [8:0]           w_drop_sum;

  assign w_cs_rise  = !cs_prev_q && cs_sync2_q;
  assign w_hdr_good = (pkt_data[127:120] == HEADER_BYTE);
  assign w_next_idx = idx_q + 4'd1;

  // A reject and an overrun can land in the same cycle (CS edge during
  // CHECK with a bad header), so the increment can be 2; clamp at 255.
  always_comb begin
    w_drop_inc = 2'd0;
    if (w_cs_rise && (state_q != ST_IDLE)) begin
      w_drop_inc = w_drop_inc + 2'd1;
    end
    if ((state_q == ST_CHECK) && !w_hdr_good) begin
      w_drop_inc = w_drop_inc + 2'd1;
    end
    w_drop_sum   = {1'b0, drop_count_q} + {7'd0, w_drop_inc};
    drop_count_d = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cs_sync1_q   <= 1'b1;
      cs_sync2_q   <= 1'b1;
      cs_prev_q    <= 1'b1;
      settle_cnt_q <= '0;
      idx_q        <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        snap_q[i] <= 8'd0;
      end
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      hdr_ok_q     <= 1'b0;
      hdr_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      pkt_count_q  <= 16'd0;
      drop_count_q <= 8'd0;
    end else begin
      cs_sync1_q   <= cs_n;
      cs_sync2_q   <= cs_sync1_q;
      cs_prev_q    <= cs_sync2_q;
      drop_count_q <= drop_count_d;

      // A new packet while one is in flight is never queued, only flagged.
      // This includes the cycle on which byte 15 is accepted.
      if (w_cs_rise && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_cs_rise && enable) begin
            settle_cnt_q <= '0;
            state_q      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == c_settle_last) begin
            state_q <= ST_CHECK;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end

        ST_CHECK: begin
          if (w_hdr_good) begin
            for (int i = 0; i < 16; i++) begin
              snap_q[i] <= pkt_data[127-8*i -: 8];
            end
            hdr_ok_q   <= 1'b1;
            hdr_err_q  <= 1'b0;
            idx_q      <= 4'd0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= pkt_data[127:120];
            tx_last_q  <= 1'b0;
            state_q    <= ST_SEND;
          end else begin
            hdr_ok_q  <= 1'b0;
            hdr_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        ST_SEND: begin
          // tx_valid_q is always high in this state; outputs move only on
          // an accepted beat, so they hold across stalls.
          if (tx_ready) begin
            if (idx_q == 4'd15) begin
              tx_valid_q  <= 1'b0;
              tx_last_q   <= 1'b0;
              pkt_count_q <= pkt_count_q + 16'd1;
              state_q     <= ST_IDLE;
            end else begin
              idx_q     <= w_next_idx;
              tx_data_q <= snap_q[w_next_idx];
              tx_last_q <= (w_next_idx == 4'd15);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;
  assign hdr_ok     = hdr_ok_q;
  assign hdr_err    = hdr_err_q;
  assign overrun    = overrun_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_packet_sequencer
// Description : Self-checking bench for packet_sequencer. It uses directed
//               scenarios plus randomised packets, ready patterns and enable
//               gating. Expected streams and counters come from a packet-level
//               model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_packet_sequencer;

  localparam int         SETTLE = 4;
  localparam logic [7:0] HDR    = 8'hAA;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs_n = 1'b1;
  logic [127:0] pkt_data = '0;
  logic         enable = 1'b1;
  logic         tx_ready = 1'b1;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_last;
  logic         busy;
  logic         hdr_ok;
  logic         hdr_err;
  logic         overrun;
  logic [15:0]  pkt_count;
  logic [7:0]   drop_count;

  packet_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .HEADER_BYTE   (HDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .pkt_data   (pkt_data),
    .enable     (enable),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .busy       (busy),
    .hdr_ok     (hdr_ok),
    .hdr_err    (hdr_err),
    .overrun    (overrun),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Packet-level model state
  int m_pkt  = 0;
  int m_drop = 0;
  bit m_ovr  = 0;
  bit m_ok   = 0;
  bit m_err  = 0;

  logic [7:0] beats [$];
  bit         lasts [$];
  int         rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [127:0] rand_pkt(input bit good);
    logic [127:0] p;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) p[127-8*i -: 8] = 8'($urandom);
    if (good) begin
      p[127:120] = HDR;
    end else begin
      do b = 8'($urandom); while (b == HDR);
      p[127:120] = b;
    end
    return p;
  endfunction

  // Ready driver
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph  = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       begin tx_ready = pat[3-ph]; ph = (ph + 1) % 4; end
        2:       tx_ready = 1'($urandom);
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Beat monitor and stall-stability check
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         prev_last;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall) begin
        check_eq("stall_valid", 32'(tx_valid), 32'd1);
        check_eq("stall_data", 32'(tx_data), 32'(prev_data));
        check_eq("stall_last", 32'(tx_last), 32'(prev_last));
      end
      prev_stall = rst_n && tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
      if (rst_n && tx_valid && tx_ready) begin
        beats.push_back(tx_data);
        lasts.push_back(tx_last);
      end
    end
  end

  task automatic model_reset();
    m_pkt = 0; m_drop = 0; m_ovr = 0; m_ok = 0; m_err = 0;
  endtask

  task automatic check_status();
    check_eq("pkt_count", 32'(pkt_count), 32'(m_pkt));
    check_eq("drop_count", 32'(drop_count), 32'(m_drop));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("hdr_ok", 32'(hdr_ok), 32'(m_ok));
    check_eq("hdr_err", 32'(hdr_err), 32'(m_err));
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("valid_idle", 32'(tx_valid), 32'd0);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_last", 32'(tx_last), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_hdr_ok", 32'(hdr_ok), 32'd0);
    check_eq("rst_hdr_err", 32'(hdr_err), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs_n  = 1'b1;
    repeat (3) tick();
    check_reset_vals();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_beats(input int want);
    int n = 0;
    while (beats.size() < want && n < 300) begin tick(); n++; end
    if (beats.size() < want) check_eq("beat_wait_timeout", 32'(beats.size()), 32'(want));
  endtask

  task automatic check_stream(input logic [127:0] p, input bit expect_data);
    if (!expect_data) begin
      check_eq("no_beats", 32'(beats.size()), 32'd0);
    end else begin
      check_eq("beat_count", 32'(beats.size()), 32'd16);
      for (int i = 0; i < 16 && i < beats.size(); i++) begin
        check_eq("beat_data", 32'(beats[i]), 32'(p[127-8*i -: 8]));
        check_eq("beat_last", 32'(lasts[i]), (i == 15) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic run_packet(input logic [127:0] p, input bit en, input bit drop_en);
    bit good;
    int lat;
    good = en && (p[127:120] == HDR);
    beats.delete();
    lasts.delete();
    enable   = en;
    pkt_data = p;
    cs_n = 1'b0;
    repeat (3) tick();
    cs_n = 1'b1;
    lat  = -1;
    for (int n = 1; n <= SETTLE + 10; n++) begin
      tick();
      if (tx_valid && lat < 0) lat = n;
      if (n == SETTLE + 4 && !good) check_eq("idle_after_reject", 32'(busy), 32'd0);
      if (n == SETTLE + 5 && drop_en) enable = 1'b0;
    end
    wait_idle(600);
    repeat (2) tick();
    if (en) begin
      if (p[127:120] == HDR) begin
        m_pkt = (m_pkt + 1) % 65536; m_ok = 1; m_err = 0;
      end else begin
        m_drop = sat255(m_drop + 1); m_ok = 0; m_err = 1;
      end
    end
    if (good) check_eq("latency", 32'(lat), 32'(SETTLE + 4));
    check_stream(p, good);
    check_status();
    enable = 1'b1;
  endtask

  initial begin
    logic [127:0] p1;
    logic [127:0] p2;
    logic [127:0] pseq;

    for (int i = 0; i < 16; i++) pseq[127-8*i -: 8] = 8'(i);
    pseq[127:120] = HDR;

    do_reset();

    // Good packet, ready held high
    rdy_mode = 0;
    run_packet(pseq, 1, 0);

    // Bad header
    p1 = rand_pkt(0);
    p1[127:120] = 8'h55;
    run_packet(p1, 1, 0);

    // Backpressure 1,0,0,1
    rdy_mode = 1;
    run_packet(pseq, 1, 0);
    run_packet(rand_pkt(1), 1, 1);

    // Gated by enable
    rdy_mode = 0;
    run_packet(rand_pkt(1), 0, 0);

    // Overrun at beat 5 with new packet data
    do_reset();
    p1 = rand_pkt(1);
    p2 = {HDR, {15{8'hFF}}};
    beats.delete(); lasts.delete();
    pkt_data = p1;
    cs_n = 1'b0; repeat (3) tick(); cs_n = 1'b1;
    wait_beats(5);
    pkt_data = p2;
    cs_n = 1'b0; repeat (3) tick(); cs_n = 1'b1;
    wait_idle(600);
    repeat (SETTLE + 10) tick();
    m_pkt = 1; m_drop = 1; m_ovr = 1; m_ok = 1;
    check_stream(p1, 1);
    check_status();

    // CS edge detected on the same cycle byte 15 is accepted
    do_reset();
    p1 = rand_pkt(1);
    beats.delete(); lasts.delete();
    pkt_data = p1;
    cs_n = 1'b0; repeat (3) tick(); cs_n = 1'b1;
    wait_beats(9);
    cs_n = 1'b0;
    wait_beats(13);
    cs_n = 1'b1;
    wait_idle(600);
    repeat (SETTLE + 10) tick();
    m_pkt = 1; m_drop = 1; m_ovr = 1; m_ok = 1;
    check_stream(p1, 1);
    check_status();

    // Reject and overrun in the same cycle adds 2
    do_reset();
    beats.delete(); lasts.delete();
    pkt_data = rand_pkt(0);
    cs_n = 1'b0; repeat (3) tick();
    cs_n = 1'b1; tick();
    cs_n = 1'b0; repeat (SETTLE) tick();
    cs_n = 1'b1;
    repeat (SETTLE + 10) tick();
    wait_idle(600);
    m_drop = 2; m_ovr = 1; m_err = 1;
    check_stream(pkt_data, 0);
    check_status();

    // Randomised packets
    for (int k = 0; k < 24; k++) begin
      rdy_mode = int'($urandom_range(0, 2));
      run_packet(rand_pkt($urandom_range(0, 3) != 0), $urandom_range(0, 7) != 0,
                 1'($urandom));
    end

    // Reset in the middle of SEND
    rdy_mode = 0;
    tick();
    beats.delete(); lasts.delete();
    pkt_data = rand_pkt(1);
    cs_n = 1'b0; repeat (3) tick(); cs_n = 1'b1;
    wait_beats(8);
    rst_n = 1'b0;
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    model_reset();
    repeat (30) tick();
    check_eq("no_beats_after_reset", 32'(beats.size()), 32'd8);
    check_status();

    // drop_count saturation
    do_reset();
    for (int k = 0; k < 258; k++) run_packet(rand_pkt(0), 1, 0);
    check_eq("drop_saturated", 32'(drop_count), 32'd255);

    // pkt_count wrap
    force dut.pkt_count_q = 16'hFFFF;
    tick();
    release dut.pkt_count_q;
    tick();
    check_eq("pkt_preload", 32'(pkt_count), 32'h0000FFFF);
    m_pkt = 16'hFFFF;
    run_packet(rand_pkt(1), 1, 0);
    check_eq("pkt_wrapped", 32'(pkt_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
